mul_share_ctrl: RTL

Arbiter and sequencer that shares one pipelined multiplier datapath between the integer M-extension unit and the FPU mantissa multiplier in stage3. The datapath is partial-product generation, the Wallace-tree carry-save reduction and the final carry-lookahead add. This block arbitrates round-robin between the two requesters and issues operands with signedness controls. It tracks every in-flight operation in a tag shift register matched to the datapath latency, then routes and formats each returning product back to its owner. Integer flushes kill in-flight integer operations without disturbing FPU traffic.

---
 rtl/mul_share_pkg.sv | 36 +++
 rtl/mul_share_ctrl_if.sv | 45 ++++
 rtl/mul_tag_pipe.sv | 42 ++++
 rtl/mul_share_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// Shared types and result formatting for the INT/FPU multiplier sharing controller.
package mul_share_pkg;

  localparam int MUL_XLEN = 64;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    MULW   = 3'd4
  } mul_op_t;

  typedef enum logic {
    OWNER_INT = 1'b0,
    OWNER_FPU = 1'b1
  } owner_e;

  typedef struct packed {
    logic    valid;
    owner_e  owner;
    mul_op_t op;
  } mul_tag_t;

  // Pick the slice of the double-width product that the integer op architecturally returns.
  function automatic logic [MUL_XLEN-1:0] fmt_int_result(mul_op_t op, logic [2*MUL_XLEN-1:0] prod);
    logic [MUL_XLEN-1:0] res;
    case (op)
      MULH, MULHSU, MULHU: res = prod[2*MUL_XLEN-1:MUL_XLEN];
      MULW:                res = {{(MUL_XLEN-32){prod[31]}}, prod[31:0]};
      default:             res = prod[MUL_XLEN-1:0];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mul_share_ctrl_if.sv
// Request, result and datapath signals of the shared-multiplier controller.
interface mul_share_ctrl_if #(
  parameter int XLEN = 64
);
  import mul_share_pkg::*;

  logic              int_valid_i;
  logic              int_ready_o;
  mul_op_t           int_op_i;
  logic [XLEN-1:0]   int_a_i;
  logic [XLEN-1:0]   int_b_i;
  logic              int_flush_i;
  logic              int_res_valid_o;
  logic [XLEN-1:0]   int_res_o;
  logic              fpu_valid_i;
  logic              fpu_ready_o;
  logic [XLEN-1:0]   fpu_a_i;
  logic [XLEN-1:0]   fpu_b_i;
  logic              fpu_res_valid_o;
  logic [2*XLEN-1:0] fpu_res_o;
  logic              mul_issue_o;
  logic [XLEN-1:0]   mul_a_o;
  logic [XLEN-1:0]   mul_b_o;
  logic              mul_a_signed_o;
  logic              mul_b_signed_o;
  logic [2*XLEN-1:0] mul_res_i;
  logic              busy_o;

  modport slave (
    input  int_valid_i, int_op_i, int_a_i, int_b_i, int_flush_i,
    input  fpu_valid_i, fpu_a_i, fpu_b_i, mul_res_i,
    output int_ready_o, int_res_valid_o, int_res_o,
    output fpu_ready_o, fpu_res_valid_o, fpu_res_o,
    output mul_issue_o, mul_a_o, mul_b_o, mul_a_signed_o, mul_b_signed_o, busy_o
  );

  modport master (
    output int_valid_i, int_op_i, int_a_i, int_b_i, int_flush_i,
    output fpu_valid_i, fpu_a_i, fpu_b_i, mul_res_i,
    input  int_ready_o, int_res_valid_o, int_res_o,
    input  fpu_ready_o, fpu_res_valid_o, fpu_res_o,
    input  mul_issue_o, mul_a_o, mul_b_o, mul_a_signed_o, mul_b_signed_o, busy_o
  );

endinterface

// File: rtl/mul_tag_pipe.sv
// LAT-deep tag shift register that shadows the multiplier datapath, with an
// owner-selective kill that invalidates integer tags anywhere in the pipe.
module mul_tag_pipe
  import mul_share_pkg::*;
#(
  parameter int LAT = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  input  mul_tag_t tag_in,
  input  logic     kill_int,
  output mul_tag_t tag_out,
  output logic     any_valid
);

  mul_tag_t stage_q [LAT];

  function automatic mul_tag_t apply_kill(mul_tag_t t, logic kill);
    mul_tag_t r;
    r = t;
    if (kill && t.owner == OWNER_INT) r.valid = 1'b0;
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= apply_kill(tag_in, kill_int);
      for (int i = 1; i < LAT; i++) stage_q[i] <= apply_kill(stage_q[i-1], kill_int);
    end
  end

  // The tail is killed combinationally too, so a flush in the result cycle still wins.
  assign tag_out = apply_kill(stage_q[LAT-1], kill_int);

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < LAT; i++) any_valid = any_valid | stage_q[i].valid;
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Round-robin arbiter and sequencer sharing one pipelined multiplier between
// the integer M-extension unit and the FPU mantissa multiplier.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int LAT  = 3,
  parameter int XLEN = MUL_XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  mul_share_ctrl_if.slave   bus
);

  owner_e            last_grant_q;
  logic              int_grant;
  logic              fpu_grant;
  mul_tag_t          issue_tag;
  mul_tag_t          tail_tag;
  logic              busy;
  logic              int_res_valid_q;
  logic              fpu_res_valid_q;
  logic [XLEN-1:0]   int_res_q;
  logic [2*XLEN-1:0] fpu_res_q;

  // A flushed integer request yields the slot to the FPU in the same cycle.
  always_comb begin
    int_grant = bus.int_valid_i && !bus.int_flush_i &&
                (!bus.fpu_valid_i || last_grant_q == OWNER_FPU);
    fpu_grant = bus.fpu_valid_i && !int_grant;
  end

  always_comb begin
    bus.mul_a_o        = bus.fpu_a_i;
    bus.mul_b_o        = bus.fpu_b_i;
    bus.mul_a_signed_o = 1'b0;
    bus.mul_b_signed_o = 1'b0;
    issue_tag          = '0;
    if (int_grant) begin
      bus.mul_a_o     = bus.int_a_i;
      bus.mul_b_o     = bus.int_b_i;
      issue_tag.valid = 1'b1;
      issue_tag.owner = OWNER_INT;
      issue_tag.op    = bus.int_op_i;
      case (bus.int_op_i)
        MULHSU: begin
          bus.mul_a_signed_o = 1'b1;
          bus.mul_b_signed_o = 1'b0;
        end
        MULHU: begin
          bus.mul_a_signed_o = 1'b0;
          bus.mul_b_signed_o = 1'b0;
        end
        default: begin
          bus.mul_a_signed_o = 1'b1;
          bus.mul_b_signed_o = 1'b1;
        end
      endcase
    end else if (fpu_grant) begin
      issue_tag.valid = 1'b1;
      issue_tag.owner = OWNER_FPU;
      issue_tag.op    = MUL;
    end
  end

  mul_tag_pipe #(.LAT(LAT)) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .tag_in    (issue_tag),
    .kill_int  (bus.int_flush_i),
    .tag_out   (tail_tag),
    .any_valid (busy)
  );

  // Result data only loads on its owner's valid, so it holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q    <= OWNER_FPU;
      int_res_valid_q <= 1'b0;
      fpu_res_valid_q <= 1'b0;
      int_res_q       <= '0;
      fpu_res_q       <= '0;
    end else begin
      int_res_valid_q <= tail_tag.valid && tail_tag.owner == OWNER_INT;
      fpu_res_valid_q <= tail_tag.valid && tail_tag.owner == OWNER_FPU;
      if (tail_tag.valid && tail_tag.owner == OWNER_INT)
        int_res_q <= fmt_int_result(tail_tag.op, bus.mul_res_i);
      if (tail_tag.valid && tail_tag.owner == OWNER_FPU)
        fpu_res_q <= bus.mul_res_i;
      if (int_grant)
        last_grant_q <= OWNER_INT;
      else if (fpu_grant)
        last_grant_q <= OWNER_FPU;
    end
  end

  assign bus.int_ready_o     = int_grant;
  assign bus.fpu_ready_o     = fpu_grant;
  assign bus.mul_issue_o     = int_grant || fpu_grant;
  assign bus.int_res_valid_o = int_res_valid_q;
  assign bus.int_res_o       = int_res_q;
  assign bus.fpu_res_valid_o = fpu_res_valid_q;
  assign bus.fpu_res_o       = fpu_res_q;
  assign bus.busy_o          = busy;

endmodule
